// File: rtl/adc_readout_sequencer.sv
// Multi-channel ADC capture buffer with SPI-paced readout.
// A trigger rising edge captures word_num+1 samples per channel into per-channel RAM;
// the SPI side then drains the channels selected by ch_mask in ascending channel order.
module adc_readout_sequencer #(
  parameter int unsigned NCH = 4,
  parameter int unsigned DW  = 16,
  parameter int unsigned AW  = 12,
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [NCH*DW-1:0] sample_data,
  input  logic              trigger,
  input  logic [AW-1:0]     word_num,
  input  logic [NCH-1:0]    ch_mask,
  input  logic              spi_ss,
  input  logic              spi_done,
  output logic [DW-1:0]     data_out,
  output logic [CW-1:0]     rd_ch,
  output logic [AW-1:0]     rd_addr,
  output logic [1:0]        state,
  output logic              ready,
  output logic              done,
  output logic              trig_lost
);

  localparam int unsigned Depth = 2 ** AW;

  typedef enum logic [1:0] {
    StArmed   = 2'd0,
    StCapture = 2'd1,
    StReady   = 2'd2,
    StReadout = 2'd3
  } state_e;

  state_e         state_q;
  logic           trigger_q;
  logic [AW-1:0]  len_q;
  logic [AW-1:0]  wr_addr_q;
  logic [CW-1:0]  rd_ch_q;
  logic [AW-1:0]  rd_addr_q;
  logic [NCH-1:0] mask_q;
  logic           done_q;
  logic           trig_lost_q;
  logic [DW-1:0]  rd_data_q;

  logic           trig_edge;
  logic           wr_en;
  logic [CW-1:0]  first_ch;
  logic [CW-1:0]  next_ch;
  logic           next_found;

  // Sample buffer, one bank per channel; contents deliberately survive reset.
  logic [DW-1:0] mem [NCH][Depth];

  assign trig_edge = trigger & ~trigger_q;
  assign wr_en     = (state_q == StCapture) && sample_valid;

  // Channel selection: lowest set bit of the incoming mask, and next set bit above rd_ch.
  always_comb begin
    first_ch   = '0;
    next_ch    = '0;
    next_found = 1'b0;
    for (int k = int'(NCH) - 1; k >= 0; k--) begin
      if (ch_mask[k]) begin
        first_ch = CW'(k);
      end
      if (mask_q[k] && (CW'(k) > rd_ch_q)) begin
        next_found = 1'b1;
        next_ch    = CW'(k);
      end
    end
  end

  // Capture write: all channels share one address and write in the same cycle.
  always_ff @(posedge sysclk) begin
    if (wr_en) begin
      for (int k = 0; k < int'(NCH); k++) begin
        mem[k][wr_addr_q] <= sample_data[k*DW +: DW];
      end
    end
  end

  // Registered read port; data follows rd_ch/rd_addr by one cycle.
  always_ff @(posedge sysclk) begin
    rd_data_q <= mem[rd_ch_q][rd_addr_q];
  end

  // Sequencer FSM with its address, channel and status registers.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q     <= StArmed;
      trigger_q   <= 1'b0;
      len_q       <= '0;
      wr_addr_q   <= '0;
      rd_ch_q     <= '0;
      rd_addr_q   <= '0;
      mask_q      <= '0;
      done_q      <= 1'b0;
      trig_lost_q <= 1'b0;
    end else begin
      trigger_q <= trigger;
      done_q    <= 1'b0;
      // Edges that cannot start a capture are only recorded, never acted on.
      if (trig_edge && (state_q != StArmed)) begin
        trig_lost_q <= 1'b1;
      end
      unique case (state_q)
        StArmed: begin
          if (trig_edge) begin
            len_q     <= word_num;
            wr_addr_q <= '0;
            state_q   <= StCapture;
          end
        end
        StCapture: begin
          if (sample_valid) begin
            // Last word holds wr_addr so a full-depth capture never wraps.
            if (wr_addr_q == len_q) begin
              state_q <= StReady;
            end else begin
              wr_addr_q <= wr_addr_q + AW'(1);
            end
          end
        end
        StReady: begin
          if (!spi_ss) begin
            mask_q    <= ch_mask;
            rd_addr_q <= '0;
            if (ch_mask == '0) begin
              rd_ch_q <= '0;
              state_q <= StArmed;
              done_q  <= 1'b1;
            end else begin
              rd_ch_q <= first_ch;
              state_q <= StReadout;
            end
          end
        end
        StReadout: begin
          if (spi_ss) begin
            // Master dropped select: rewind, keep buffer for a full re-read.
            rd_addr_q <= '0;
            rd_ch_q   <= '0;
            state_q   <= StReady;
          end else if (spi_done) begin
            if (rd_addr_q < len_q) begin
              rd_addr_q <= rd_addr_q + AW'(1);
            end else begin
              rd_addr_q <= '0;
              if (next_found) begin
                rd_ch_q <= next_ch;
              end else begin
                rd_ch_q <= '0;
                state_q <= StArmed;
                done_q  <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q <= StArmed;
        end
      endcase
    end
  end

  assign data_out  = ((state_q == StReady) || (state_q == StReadout)) ? rd_data_q : '0;
  assign rd_ch     = rd_ch_q;
  assign rd_addr   = rd_addr_q;
  assign state     = state_q;
  assign ready     = (state_q == StReady);
  assign done      = done_q;
  assign trig_lost = trig_lost_q;

endmodule

// File: tb/tb_adc_readout_sequencer.sv
// Directed + randomized bench for adc_readout_sequencer against a buffer/readout-order model.
module tb_adc_readout_sequencer;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int AW  = 12;

  logic              sysclk = 1'b0;
  logic              rst;
  logic              sample_valid;
  logic [NCH*DW-1:0] sample_data;
  logic              trigger;
  logic [AW-1:0]     word_num;
  logic [NCH-1:0]    ch_mask;
  logic              spi_ss;
  logic              spi_done;
  logic [DW-1:0]     data_out;
  logic [1:0]        rd_ch;
  logic [AW-1:0]     rd_addr;
  logic [1:0]        state;
  logic              ready;
  logic              done;
  logic              trig_lost;

  int total = 0;
  int bad   = 0;

  // Model: what each channel should hold, capture length, and sticky lost-trigger flag.
  logic [DW-1:0] exp_buf [NCH][2**AW];
  int            model_len;
  logic          model_lost;

  adc_readout_sequencer #(.NCH(NCH), .DW(DW), .AW(AW)) dut (
    .sysclk       (sysclk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .trigger      (trigger),
    .word_num     (word_num),
    .ch_mask      (ch_mask),
    .spi_ss       (spi_ss),
    .spi_done     (spi_done),
    .data_out     (data_out),
    .rd_ch        (rd_ch),
    .rd_addr      (rd_addr),
    .state        (state),
    .ready        (ready),
    .done         (done),
    .trig_lost    (trig_lost)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_ready"}, 32'(ready), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_rdch"}, 32'(rd_ch), 0);
    check({tag, "_rdaddr"}, 32'(rd_addr), 0);
    check({tag, "_dout"}, 32'(data_out), 0);
    check({tag, "_lost"}, 32'(trig_lost), 32'(model_lost));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    model_lost = 1'b0;
    check_idle("rst");
    rst = 1'b0;
  endtask

  // Capture len+1 samples; pattern selects 0x100*k+n data, gaps inserts 3 idle cycles
  // before each sample, trig_at injects a second trigger edge with that sample.
  task automatic capture(input int len, input bit pattern, input int trig_at, input bit gaps);
    logic [DW-1:0] v;
    word_num = AW'(len);
    trigger  = 1'b1;
    tick();
    trigger   = 1'b0;
    model_len = len;
    check("cap_start", 32'(state), 1);
    check("cap_dout0", 32'(data_out), 0);
    for (int n = 0; n <= len; n++) begin
      if (gaps) begin
        sample_valid = 1'b0;
        sample_data  = {$urandom, $urandom};
        repeat (3) tick();
      end
      for (int k = 0; k < NCH; k++) begin
        v = pattern ? DW'(256 * k + n) : DW'($urandom);
        sample_data[k*DW +: DW] = v;
        exp_buf[k][n] = v;
      end
      sample_valid = 1'b1;
      if (n == trig_at) begin
        trigger    = 1'b1;
        model_lost = 1'b1;
      end
      tick();
      trigger = 1'b0;
    end
    sample_valid = 1'b0;
    check("cap_ready_state", 32'(state), 2);
    check("cap_ready", 32'(ready), 1);
    check("cap_lost", 32'(trig_lost), 32'(model_lost));
    // Stray samples after the buffer is full must not land anywhere.
    sample_data  = {$urandom, $urandom};
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("ready_hold", 32'(state), 2);
  endtask

  // Read out mask channels; abort_after drops spi_ss after that many words,
  // trig_at raises a trigger edge together with that word's spi_done.
  task automatic readout(input logic [NCH-1:0] mask, input int abort_after, input int trig_at);
    int n;
    ch_mask = mask;
    spi_ss  = 1'b0;
    tick();
    if (mask == '0) begin
      check("mz_state", 32'(state), 0);
      check("mz_done", 32'(done), 1);
      tick();
      check("mz_done_off", 32'(done), 0);
      spi_ss = 1'b1;
      return;
    end
    check("ro_state", 32'(state), 3);
    check("ro_ready", 32'(ready), 0);
    n = 0;
    for (int c = 0; c < NCH; c++) begin
      if (mask[c]) begin
        for (int a = 0; a <= model_len; a++) begin
          tick();
          check("ro_ch", 32'(rd_ch), 32'(c));
          check("ro_addr", 32'(rd_addr), 32'(a));
          check("ro_data", 32'(data_out), 32'(exp_buf[c][a]));
          if (n == abort_after) begin
            spi_ss = 1'b1;
            tick();
            check("ab_state", 32'(state), 2);
            check("ab_ready", 32'(ready), 1);
            check("ab_addr", 32'(rd_addr), 0);
            check("ab_ch", 32'(rd_ch), 0);
            return;
          end
          spi_done = 1'b1;
          if (n == trig_at) begin
            trigger    = 1'b1;
            model_lost = 1'b1;
          end
          tick();
          spi_done = 1'b0;
          trigger  = 1'b0;
          n++;
        end
      end
    end
    check("end_state", 32'(state), 0);
    check("end_done", 32'(done), 1);
    check("end_lost", 32'(trig_lost), 32'(model_lost));
    tick();
    check("end_done_off", 32'(done), 0);
    check("end_dout", 32'(data_out), 0);
    spi_ss = 1'b1;
  endtask

  initial begin
    logic [NCH-1:0] m;
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;
    trigger      = 1'b0;
    word_num     = '0;
    ch_mask      = '0;
    spi_ss       = 1'b1;
    spi_done     = 1'b0;
    model_lost   = 1'b0;
    model_len    = 0;
    tick();
    do_reset();

    // Full four-channel readout of a known pattern.
    capture(3, 1'b1, -1, 1'b0);
    readout(4'hF, -1, -1);

    // Sparse mask: channels 1 and 3 only.
    capture(3, 1'b1, -1, 1'b0);
    readout(4'b1010, -1, -1);

    // Abort after two words, then a complete re-read with a lost trigger mid-way.
    capture(3, 1'b0, -1, 1'b0);
    readout(4'hF, 2, -1);
    readout(4'hF, -1, 1);

    // Trigger during capture and gapped sample_valid.
    capture(5, 1'b0, 2, 1'b1);
    readout(4'b0101, -1, -1);

    // Reset mid-capture clears everything including trig_lost.
    word_num = AW'(3);
    trigger  = 1'b1;
    tick();
    trigger = 1'b0;
    for (int n = 0; n < 2; n++) begin
      sample_data  = {$urandom, $urandom};
      sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    check("mid_cap_state", 32'(state), 1);
    do_reset();

    // Empty mask goes straight back to armed with a done pulse.
    capture(2, 1'b0, -1, 1'b0);
    readout('0, -1, -1);
    check("mz_armed", 32'(state), 0);

    // Random short captures and masks, including single-word length.
    for (int i = 0; i < 4; i++) begin
      m = NCH'($urandom);
      capture((i == 0) ? 0 : int'($urandom_range(7)), 1'b0, -1, 1'b0);
      readout(m, -1, -1);
    end

    // Full-depth capture, no wrap, full channel-0 readout.
    capture(2 ** AW - 1, 1'b0, -1, 1'b0);
    readout(4'b0001, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
